pads_rst_seq: RTL and testbench

Reset and power-up sequencer that sits directly downstream of the pad ring, between the chip reset/power pads and the core.
- Takes the raw asynchronous chip reset arriving through the reset input pad.
- Synchronises its deassertion and stretches it.
- Releases the design in order: I/O pad output enables first, then core reset, then instruction fetch.
- Also handles software-requested resets and provides a test-mode bypass for scan.

---
 rtl/pads_rst_seq.sv | 145 ++++++++++++++
 tb/tb_pads_rst_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pads_rst_seq.sv
// Reset and power-up sequencer between the chip reset pad and the core.
// Releases pad output enables, then core reset, then fetch, with software reset and scan bypass.
module pads_rst_seq #(
  parameter int SYNC_STAGES  = 2,
  parameter int IO_DELAY     = 16,
  parameter int CORE_DELAY   = 16,
  parameter int SWRST_CYCLES = 8,
  parameter int CNT_W        = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       test_mode_i,
  input  logic       sw_rst_req_i,
  output logic       pad_oe_en_o,
  output logic       core_rst_no,
  output logic       fetch_en_o,
  output logic [2:0] state_o,
  output logic [1:0] rst_cause_o
);

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_IO    = 3'd1,
    ST_CORE  = 3'd2,
    ST_FETCH = 3'd3,
    ST_RUN   = 3'd4,
    ST_SWRST = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] IO_LAST    = CNT_W'(IO_DELAY - 1);
  localparam logic [CNT_W-1:0] CORE_LAST  = CNT_W'(CORE_DELAY - 1);
  localparam logic [CNT_W-1:0] SWRST_LAST = CNT_W'(SWRST_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pad_q, pad_d;
  logic             core_q, core_d;
  logic             fetch_q, fetch_d;
  logic [1:0]       cause_q, cause_d;

  // Assertion is immediate through the async clear; only the release is synchronised.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_SYNC;
      cnt_q   <= '0;
      pad_q   <= 1'b0;
      core_q  <= 1'b0;
      fetch_q <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pad_q   <= pad_d;
      core_q  <= core_d;
      fetch_q <= fetch_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pad_d   = pad_q;
    core_d  = core_q;
    fetch_d = fetch_q;
    cause_d = cause_q;
    case (state_q)
      ST_SYNC: begin
        if (rst_sync) begin
          state_d = ST_IO;
          cnt_d   = '0;
        end
      end
      ST_IO: begin
        if (cnt_q == IO_LAST) begin
          state_d = ST_CORE;
          cnt_d   = '0;
          pad_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CORE: begin
        if (cnt_q == CORE_LAST) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
          core_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FETCH: begin
        state_d = ST_RUN;
        fetch_d = 1'b1;
      end
      ST_RUN: begin
        if (sw_rst_req_i) begin
          state_d = ST_SWRST;
          cnt_d   = '0;
          core_d  = 1'b0;
          fetch_d = 1'b0;
          cause_d = CAUSE_SW;
        end
      end
      ST_SWRST: begin
        // Requests arriving here are deliberately ignored so the hold length is fixed.
        if (cnt_q == SWRST_LAST) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
          core_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_SYNC;
        cnt_d   = '0;
      end
    endcase
  end

  // Scan bypass hands core reset straight to the pad while the FSM keeps running.
  assign core_rst_no = test_mode_i ? rst_ni : core_q;
  assign pad_oe_en_o = test_mode_i ? 1'b1   : pad_q;
  assign fetch_en_o  = test_mode_i ? 1'b0   : fetch_q;
  assign state_o     = state_q;
  assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_pads_rst_seq.sv
// Directed bench for pads_rst_seq: default instance plus a short-delay instance.
// Expected vectors are pushed to a scoreboard queue and popped after each edge.
module tb_pads_rst_seq;

  logic       clk_i = 1'b0;
  logic       rst_ni, test_mode_i, sw_rst_req_i;
  logic       pad_oe_en_o, core_rst_no, fetch_en_o;
  logic [2:0] state_o;
  logic [1:0] rst_cause_o;

  logic       rst2_n;
  logic       pad2, core2, fetch2;
  logic [2:0] state2;
  logic [1:0] cause2;

  always #5 clk_i = ~clk_i;

  pads_rst_seq dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .test_mode_i  (test_mode_i),
    .sw_rst_req_i (sw_rst_req_i),
    .pad_oe_en_o  (pad_oe_en_o),
    .core_rst_no  (core_rst_no),
    .fetch_en_o   (fetch_en_o),
    .state_o      (state_o),
    .rst_cause_o  (rst_cause_o)
  );

  pads_rst_seq #(.SYNC_STAGES(3), .IO_DELAY(1), .CORE_DELAY(1)) dut_fast (
    .clk_i        (clk_i),
    .rst_ni       (rst2_n),
    .test_mode_i  (1'b0),
    .sw_rst_req_i (1'b0),
    .pad_oe_en_o  (pad2),
    .core_rst_no  (core2),
    .fetch_en_o   (fetch2),
    .state_o      (state2),
    .rst_cause_o  (cause2)
  );

  // Observed vector layout: {pad_oe, core_rst_n, fetch_en, state[2:0], cause[1:0]}
  logic [7:0] obs1, obs2;
  assign obs1 = {pad_oe_en_o, core_rst_no, fetch_en_o, state_o, rst_cause_o};
  assign obs2 = {pad2, core2, fetch2, state2, cause2};

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Closed-form expectation n edges after reset release.
  function automatic logic [7:0] seq_exp(int n, int s, int io, int cd, logic [1:0] cause);
    int t_io, t_core, t_fetch, t_run;
    logic [2:0] st;
    t_io    = s + 1;
    t_core  = t_io + io;
    t_fetch = t_core + cd;
    t_run   = t_fetch + 1;
    if (n >= t_run)        st = 3'd4;
    else if (n >= t_fetch) st = 3'd3;
    else if (n >= t_core)  st = 3'd2;
    else if (n >= t_io)    st = 3'd1;
    else                   st = 3'd0;
    return {(n >= t_core), (n >= t_fetch), (n >= t_run), st, cause};
  endfunction

  task automatic push_exp(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_output(input int which);
    exp_t       e;
    logic [7:0] obs;
    obs = (which == 2) ? obs2 : obs1;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL sb_underflow observed=%b expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic [7:0] v, input int which);
    push_exp(tag, v);
    @(posedge clk_i);
    @(negedge clk_i);
    check_output(which);
  endtask

  initial begin
    logic [7:0] v;
    rst_ni       = 1'b0;
    rst2_n       = 1'b0;
    test_mode_i  = 1'b0;
    sw_rst_req_i = 1'b0;

    repeat (5) @(negedge clk_i);
    push_exp("reset_values", 8'b000_000_01);
    check_output(1);

    $display("[TB] power-up sequence");
    rst_ni = 1'b1;
    for (int n = 1; n <= 40; n++)
      apply_stimulus($sformatf("pwrup_e%0d", n), seq_exp(n, 2, 16, 16, 2'b01), 1);

    $display("[TB] async reset in ST_CORE, then ignored request in ST_IO");
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int n = 1; n <= 25; n++)
      apply_stimulus($sformatf("pre_abort_e%0d", n), seq_exp(n, 2, 16, 16, 2'b01), 1);
    #2 rst_ni = 1'b0;
    #1 push_exp("async_abort", 8'b000_000_01);
    check_output(1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 10) sw_rst_req_i = 1'b1;
      apply_stimulus($sformatf("rerun_e%0d", n), seq_exp(n, 2, 16, 16, 2'b01), 1);
      sw_rst_req_i = 1'b0;
    end

    $display("[TB] software reset with ignored re-request");
    for (int k = 0; k <= 10; k++) begin
      if (k == 0 || k == 3) sw_rst_req_i = 1'b1;
      v = {1'b1, (k >= 8), (k >= 9),
           (k < 8) ? 3'd5 : ((k == 8) ? 3'd3 : 3'd4), 2'b10};
      apply_stimulus($sformatf("swrst_k%0d", k), v, 1);
      sw_rst_req_i = 1'b0;
    end

    #2 rst_ni = 1'b0;
    #1 push_exp("pad_reset_cause", 8'b000_000_01);
    check_output(1);

    $display("[TB] test-mode bypass");
    @(negedge clk_i);
    test_mode_i = 1'b1;
    #1 push_exp("tm_rst_low", 8'b100_000_01);
    check_output(1);
    #1 rst_ni = 1'b1;
    #1 push_exp("tm_rst_high", 8'b110_000_01);
    check_output(1);
    #1 rst_ni = 1'b0;
    #1 push_exp("tm_rst_low_again", 8'b100_000_01);
    check_output(1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      v = seq_exp(n, 2, 16, 16, 2'b01);
      v[7:5] = 3'b110;
      apply_stimulus($sformatf("tm_run_e%0d", n), v, 1);
    end
    test_mode_i = 1'b0;
    #1 push_exp("tm_exit_run", 8'b111_100_01);
    check_output(1);

    $display("[TB] short-delay instance");
    @(negedge clk_i);
    push_exp("fast_reset", 8'b000_000_01);
    check_output(2);
    rst2_n = 1'b1;
    for (int n = 1; n <= 10; n++)
      apply_stimulus($sformatf("fast_e%0d", n), seq_exp(n, 3, 1, 1, 2'b01), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
